// File: rtl/instr_encoder.sv
// Instruction word encoder for control_unit: packs opsel and register/immediate
// fields into 32-bit words and queues them in a small FIFO with valid/ready on both sides.
module instr_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opsel,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        err_illegal,
    output logic [15:0] instr_count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned IW = 32;
    localparam int unsigned NW = 16;

    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] occ;
    logic [IW-1:0] word_c;
    logic          legal_c;
    logic          accept_c;
    logic          push_c;
    logic          pop_c;

    // Field packing; unused fields of each format are forced to zero
    always_comb begin
        word_c  = '0;
        legal_c = 1'b1;
        case (in_opsel)
            4'd0:    word_c = {6'b000000, in_rs, in_rt, in_rd, 7'b0, 4'b0000};
            4'd1:    word_c = {6'b000000, in_rs, in_rt, in_rd, 7'b0, 4'b0010};
            4'd2:    word_c = {6'b000000, in_rs, in_rt, in_rd, 7'b0, 4'b0100};
            4'd3:    word_c = {6'b000000, in_rs, in_rt, in_rd, 7'b0, 4'b0101};
            4'd4:    word_c = {6'b000000, in_rs, in_rt, in_rd, 7'b0, 4'b1010};
            4'd5:    word_c = {6'b001000, in_rs, in_rt, in_imm};
            4'd6:    word_c = {6'b001100, in_rs, in_rt, in_imm};
            4'd7:    word_c = {6'b001101, in_rs, in_rt, in_imm};
            4'd8:    word_c = {6'b001010, in_rs, in_rt, in_imm};
            4'd9:    word_c = {6'b101011, in_rs, in_rt, in_imm};
            4'd10:   word_c = {6'b100011, in_rs, in_rt, in_imm};
            4'd11:   word_c = {6'b000010, 10'b0, in_imm};
            default: legal_c = 1'b0;
        endcase
    end

    // Handshake status depends only on the registered occupancy
    assign in_ready  = (occ < CW'(DEPTH));
    assign out_valid = (occ != '0);
    assign out_instr = mem[rd_ptr];

    assign accept_c = in_valid && in_ready;
    assign push_c   = accept_c && legal_c;
    assign pop_c    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            err_illegal <= 1'b0;
            instr_count <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= word_c;
                wr_ptr      <= wr_ptr + AW'(1);
                instr_count <= instr_count + NW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   occ <= occ + CW'(1);
                2'b01:   occ <= occ - CW'(1);
                default: occ <= occ;
            endcase
            err_illegal <= accept_c && !legal_c;
        end
    end
endmodule
